// File: rtl/axi_addr_guard.sv
// axi_addr_guard: AXI4 address-window guard in front of a device slave port.
// In-window requests pass straight through to the downstream port with no
// added latency. Out-of-window requests are absorbed locally and answered
// with DECERR, so the device never sees them and the bus never hangs.
// At most one transaction is outstanding per direction.
//
// Ports:
//   aclk, areset      clock, asynchronous active-high reset
//   slv_aw_*/slv_w_*/slv_b_*/slv_ar_*/slv_r_*   upstream AXI4 slave side
//   mst_aw_*/mst_w_*/mst_b_*/mst_ar_*/mst_r_*   downstream AXI4 master side
//   err_cnt           saturating count of terminated transactions
//   err_addr          address of the most recent terminated transaction
//   err_pulse         one-cycle pulse after each out-of-window AW/AR handshake
module axi_addr_guard #(
  parameter logic [31:0] ADDR_BASE = 32'h1c00_0000,
  parameter logic [31:0] ADDR_MASK = 32'hff00_0000,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned ID_W     = 4,
  localparam int unsigned ADDR_W   = 32,
  localparam int unsigned DATA_W   = 32,
  localparam int unsigned STRB_W   = DATA_W / 8,
  localparam int unsigned USER_W   = 1
) (
  input  logic              aclk,
  input  logic              areset,
  // upstream AW
  input  logic [ID_W-1:0]   slv_aw_id,
  input  logic [ADDR_W-1:0] slv_aw_addr,
  input  logic [7:0]        slv_aw_len,
  input  logic [2:0]        slv_aw_size,
  input  logic [1:0]        slv_aw_burst,
  input  logic              slv_aw_lock,
  input  logic [3:0]        slv_aw_cache,
  input  logic [2:0]        slv_aw_prot,
  input  logic [3:0]        slv_aw_qos,
  input  logic [3:0]        slv_aw_region,
  input  logic [USER_W-1:0] slv_aw_user,
  input  logic              slv_aw_valid,
  output logic              slv_aw_ready,
  // upstream W
  input  logic [DATA_W-1:0] slv_w_data,
  input  logic [STRB_W-1:0] slv_w_strb,
  input  logic              slv_w_last,
  input  logic [USER_W-1:0] slv_w_user,
  input  logic              slv_w_valid,
  output logic              slv_w_ready,
  // upstream B
  output logic [ID_W-1:0]   slv_b_id,
  output logic [1:0]        slv_b_resp,
  output logic [USER_W-1:0] slv_b_user,
  output logic              slv_b_valid,
  input  logic              slv_b_ready,
  // upstream AR
  input  logic [ID_W-1:0]   slv_ar_id,
  input  logic [ADDR_W-1:0] slv_ar_addr,
  input  logic [7:0]        slv_ar_len,
  input  logic [2:0]        slv_ar_size,
  input  logic [1:0]        slv_ar_burst,
  input  logic              slv_ar_lock,
  input  logic [3:0]        slv_ar_cache,
  input  logic [2:0]        slv_ar_prot,
  input  logic [3:0]        slv_ar_qos,
  input  logic [3:0]        slv_ar_region,
  input  logic [USER_W-1:0] slv_ar_user,
  input  logic              slv_ar_valid,
  output logic              slv_ar_ready,
  // upstream R
  output logic [ID_W-1:0]   slv_r_id,
  output logic [DATA_W-1:0] slv_r_data,
  output logic [1:0]        slv_r_resp,
  output logic              slv_r_last,
  output logic [USER_W-1:0] slv_r_user,
  output logic              slv_r_valid,
  input  logic              slv_r_ready,
  // downstream AW
  output logic [ID_W-1:0]   mst_aw_id,
  output logic [ADDR_W-1:0] mst_aw_addr,
  output logic [7:0]        mst_aw_len,
  output logic [2:0]        mst_aw_size,
  output logic [1:0]        mst_aw_burst,
  output logic              mst_aw_lock,
  output logic [3:0]        mst_aw_cache,
  output logic [2:0]        mst_aw_prot,
  output logic [3:0]        mst_aw_qos,
  output logic [3:0]        mst_aw_region,
  output logic [USER_W-1:0] mst_aw_user,
  output logic              mst_aw_valid,
  input  logic              mst_aw_ready,
  // downstream W
  output logic [DATA_W-1:0] mst_w_data,
  output logic [STRB_W-1:0] mst_w_strb,
  output logic              mst_w_last,
  output logic [USER_W-1:0] mst_w_user,
  output logic              mst_w_valid,
  input  logic              mst_w_ready,
  // downstream B
  input  logic [ID_W-1:0]   mst_b_id,
  input  logic [1:0]        mst_b_resp,
  input  logic [USER_W-1:0] mst_b_user,
  input  logic              mst_b_valid,
  output logic              mst_b_ready,
  // downstream AR
  output logic [ID_W-1:0]   mst_ar_id,
  output logic [ADDR_W-1:0] mst_ar_addr,
  output logic [7:0]        mst_ar_len,
  output logic [2:0]        mst_ar_size,
  output logic [1:0]        mst_ar_burst,
  output logic              mst_ar_lock,
  output logic [3:0]        mst_ar_cache,
  output logic [2:0]        mst_ar_prot,
  output logic [3:0]        mst_ar_qos,
  output logic [3:0]        mst_ar_region,
  output logic [USER_W-1:0] mst_ar_user,
  output logic              mst_ar_valid,
  input  logic              mst_ar_ready,
  // downstream R
  input  logic [ID_W-1:0]   mst_r_id,
  input  logic [DATA_W-1:0] mst_r_data,
  input  logic [1:0]        mst_r_resp,
  input  logic              mst_r_last,
  input  logic [USER_W-1:0] mst_r_user,
  input  logic              mst_r_valid,
  output logic              mst_r_ready,
  // status
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_pulse
);

  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {W_IDLE, W_PASS, W_PASS_B, W_ERR, W_ERR_B} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_PASS, R_ERR} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [ID_W-1:0] b_id_q;
  logic [ID_W-1:0] r_id_q;
  logic [7:0]      r_beat_q;
  logic            aw_in_range, ar_in_range;
  logic            aw_err_hs, ar_err_hs;
  logic            r_beat_dec;
  logic [SUM_W-1:0] cnt_sum;

  assign aw_in_range = (slv_aw_addr & ADDR_MASK) == ADDR_BASE;
  assign ar_in_range = (slv_ar_addr & ADDR_MASK) == ADDR_BASE;

  // Request payloads always flow downstream; only the valids are gated.
  assign mst_aw_id     = slv_aw_id;
  assign mst_aw_addr   = slv_aw_addr;
  assign mst_aw_len    = slv_aw_len;
  assign mst_aw_size   = slv_aw_size;
  assign mst_aw_burst  = slv_aw_burst;
  assign mst_aw_lock   = slv_aw_lock;
  assign mst_aw_cache  = slv_aw_cache;
  assign mst_aw_prot   = slv_aw_prot;
  assign mst_aw_qos    = slv_aw_qos;
  assign mst_aw_region = slv_aw_region;
  assign mst_aw_user   = slv_aw_user;
  assign mst_w_data    = slv_w_data;
  assign mst_w_strb    = slv_w_strb;
  assign mst_w_last    = slv_w_last;
  assign mst_w_user    = slv_w_user;
  assign mst_ar_id     = slv_ar_id;
  assign mst_ar_addr   = slv_ar_addr;
  assign mst_ar_len    = slv_ar_len;
  assign mst_ar_size   = slv_ar_size;
  assign mst_ar_burst  = slv_ar_burst;
  assign mst_ar_lock   = slv_ar_lock;
  assign mst_ar_cache  = slv_ar_cache;
  assign mst_ar_prot   = slv_ar_prot;
  assign mst_ar_qos    = slv_ar_qos;
  assign mst_ar_region = slv_ar_region;
  assign mst_ar_user   = slv_ar_user;

  // Write FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) w_state_q <= W_IDLE;
    else        w_state_q <= w_state_d;
  end

  // Write FSM next state and handshake steering.
  always_comb begin
    w_state_d    = w_state_q;
    slv_aw_ready = 1'b0;
    mst_aw_valid = 1'b0;
    slv_w_ready  = 1'b0;
    mst_w_valid  = 1'b0;
    slv_b_valid  = 1'b0;
    mst_b_ready  = 1'b0;
    slv_b_id     = mst_b_id;
    slv_b_resp   = mst_b_resp;
    slv_b_user   = mst_b_user;
    aw_err_hs    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_in_range) begin
          mst_aw_valid = slv_aw_valid;
          slv_aw_ready = mst_aw_ready;
          if (slv_aw_valid && mst_aw_ready) w_state_d = W_PASS;
        end else begin
          // Local accept is held off during reset so no ready leaks out.
          slv_aw_ready = !areset;
          if (slv_aw_valid && !areset) begin
            aw_err_hs = 1'b1;
            w_state_d = W_ERR;
          end
        end
      end
      W_PASS: begin
        mst_w_valid = slv_w_valid;
        slv_w_ready = mst_w_ready;
        if (slv_w_valid && mst_w_ready && slv_w_last) w_state_d = W_PASS_B;
      end
      W_PASS_B: begin
        slv_b_valid = mst_b_valid;
        mst_b_ready = slv_b_ready;
        if (mst_b_valid && slv_b_ready) w_state_d = W_IDLE;
      end
      W_ERR: begin
        slv_w_ready = 1'b1;
        if (slv_w_valid && slv_w_last) w_state_d = W_ERR_B;
      end
      W_ERR_B: begin
        slv_b_valid = 1'b1;
        slv_b_id    = b_id_q;
        slv_b_resp  = RESP_DECERR;
        slv_b_user  = '0;
        if (slv_b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state_q <= R_IDLE;
    else        r_state_q <= r_state_d;
  end

  // Read FSM next state and handshake steering.
  always_comb begin
    r_state_d    = r_state_q;
    slv_ar_ready = 1'b0;
    mst_ar_valid = 1'b0;
    slv_r_valid  = 1'b0;
    mst_r_ready  = 1'b0;
    slv_r_id     = mst_r_id;
    slv_r_data   = mst_r_data;
    slv_r_resp   = mst_r_resp;
    slv_r_last   = mst_r_last;
    slv_r_user   = mst_r_user;
    ar_err_hs    = 1'b0;
    r_beat_dec   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_in_range) begin
          mst_ar_valid = slv_ar_valid;
          slv_ar_ready = mst_ar_ready;
          if (slv_ar_valid && mst_ar_ready) r_state_d = R_PASS;
        end else begin
          slv_ar_ready = !areset;
          if (slv_ar_valid && !areset) begin
            ar_err_hs = 1'b1;
            r_state_d = R_ERR;
          end
        end
      end
      R_PASS: begin
        slv_r_valid = mst_r_valid;
        mst_r_ready = slv_r_ready;
        if (mst_r_valid && slv_r_ready && mst_r_last) r_state_d = R_IDLE;
      end
      R_ERR: begin
        slv_r_valid = 1'b1;
        slv_r_id    = r_id_q;
        slv_r_data  = '0;
        slv_r_resp  = RESP_DECERR;
        slv_r_last  = (r_beat_q == 8'd0);
        slv_r_user  = '0;
        if (slv_r_ready) begin
          r_beat_dec = 1'b1;
          if (r_beat_q == 8'd0) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Error-response context: B id, R id and remaining R beats.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      b_id_q   <= '0;
      r_id_q   <= '0;
      r_beat_q <= '0;
    end else begin
      if (aw_err_hs) b_id_q <= slv_aw_id;
      if (ar_err_hs) begin
        r_id_q   <= slv_ar_id;
        r_beat_q <= slv_ar_len;
      end else if (r_beat_dec && r_beat_q != 8'd0) begin
        r_beat_q <= r_beat_q - 8'd1;
      end
    end
  end

  // One extra bit catches the carry so the count can clamp at all-ones.
  assign cnt_sum = {1'b0, err_cnt} + SUM_W'(aw_err_hs) + SUM_W'(ar_err_hs);

  // Error statistics; the AR address wins when both channels fault together.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_cnt   <= '0;
      err_addr  <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= aw_err_hs | ar_err_hs;
      err_cnt   <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      if (ar_err_hs)      err_addr <= slv_ar_addr;
      else if (aw_err_hs) err_addr <= slv_aw_addr;
    end
  end

endmodule

// File: tb/tb_axi_addr_guard.sv
// Directed testbench for axi_addr_guard. A second instance with a 2-bit
// error counter shares every input with the main one; its outputs must track
// the main instance except for the counter, which must clamp at 3.
module tb_axi_addr_guard;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  // upstream side
  logic [3:0] slv_aw_id, slv_aw_cache, slv_aw_qos, slv_aw_region;
  logic [31:0] slv_aw_addr; logic [7:0] slv_aw_len; logic [2:0] slv_aw_size, slv_aw_prot;
  logic [1:0] slv_aw_burst; logic slv_aw_lock, slv_aw_user, slv_aw_valid, slv_aw_ready;
  logic [31:0] slv_w_data; logic [3:0] slv_w_strb; logic slv_w_last, slv_w_user, slv_w_valid, slv_w_ready;
  logic [3:0] slv_b_id; logic [1:0] slv_b_resp; logic slv_b_user, slv_b_valid, slv_b_ready;
  logic [3:0] slv_ar_id, slv_ar_cache, slv_ar_qos, slv_ar_region;
  logic [31:0] slv_ar_addr; logic [7:0] slv_ar_len; logic [2:0] slv_ar_size, slv_ar_prot;
  logic [1:0] slv_ar_burst; logic slv_ar_lock, slv_ar_user, slv_ar_valid, slv_ar_ready;
  logic [3:0] slv_r_id; logic [31:0] slv_r_data; logic [1:0] slv_r_resp;
  logic slv_r_last, slv_r_user, slv_r_valid, slv_r_ready;
  // downstream side
  logic [3:0] mst_aw_id, mst_aw_cache, mst_aw_qos, mst_aw_region;
  logic [31:0] mst_aw_addr; logic [7:0] mst_aw_len; logic [2:0] mst_aw_size, mst_aw_prot;
  logic [1:0] mst_aw_burst; logic mst_aw_lock, mst_aw_user, mst_aw_valid, mst_aw_ready;
  logic [31:0] mst_w_data; logic [3:0] mst_w_strb; logic mst_w_last, mst_w_user, mst_w_valid, mst_w_ready;
  logic [3:0] mst_b_id; logic [1:0] mst_b_resp; logic mst_b_user, mst_b_valid, mst_b_ready;
  logic [3:0] mst_ar_id, mst_ar_cache, mst_ar_qos, mst_ar_region;
  logic [31:0] mst_ar_addr; logic [7:0] mst_ar_len; logic [2:0] mst_ar_size, mst_ar_prot;
  logic [1:0] mst_ar_burst; logic mst_ar_lock, mst_ar_user, mst_ar_valid, mst_ar_ready;
  logic [3:0] mst_r_id; logic [31:0] mst_r_data; logic [1:0] mst_r_resp;
  logic mst_r_last, mst_r_user, mst_r_valid, mst_r_ready;
  logic [15:0] err_cnt; logic [31:0] err_addr; logic err_pulse;

  // outputs of the 2-bit-counter instance
  logic s_slv_aw_ready, s_slv_w_ready, s_slv_ar_ready;
  logic [3:0] s_slv_b_id; logic [1:0] s_slv_b_resp; logic s_slv_b_user, s_slv_b_valid;
  logic [3:0] s_slv_r_id; logic [31:0] s_slv_r_data; logic [1:0] s_slv_r_resp;
  logic s_slv_r_last, s_slv_r_user, s_slv_r_valid;
  logic [3:0] s_mst_aw_id, s_mst_aw_cache, s_mst_aw_qos, s_mst_aw_region;
  logic [31:0] s_mst_aw_addr; logic [7:0] s_mst_aw_len; logic [2:0] s_mst_aw_size, s_mst_aw_prot;
  logic [1:0] s_mst_aw_burst; logic s_mst_aw_lock, s_mst_aw_user, s_mst_aw_valid;
  logic [31:0] s_mst_w_data; logic [3:0] s_mst_w_strb; logic s_mst_w_last, s_mst_w_user, s_mst_w_valid;
  logic s_mst_b_ready, s_mst_r_ready;
  logic [3:0] s_mst_ar_id, s_mst_ar_cache, s_mst_ar_qos, s_mst_ar_region;
  logic [31:0] s_mst_ar_addr; logic [7:0] s_mst_ar_len; logic [2:0] s_mst_ar_size, s_mst_ar_prot;
  logic [1:0] s_mst_ar_burst; logic s_mst_ar_lock, s_mst_ar_user, s_mst_ar_valid;
  logic [1:0] s_err_cnt; logic [31:0] s_err_addr; logic s_err_pulse;

  axi_addr_guard u_dut (
    .aclk(aclk), .areset(areset),
    .slv_aw_id(slv_aw_id), .slv_aw_addr(slv_aw_addr), .slv_aw_len(slv_aw_len), .slv_aw_size(slv_aw_size),
    .slv_aw_burst(slv_aw_burst), .slv_aw_lock(slv_aw_lock), .slv_aw_cache(slv_aw_cache), .slv_aw_prot(slv_aw_prot),
    .slv_aw_qos(slv_aw_qos), .slv_aw_region(slv_aw_region), .slv_aw_user(slv_aw_user),
    .slv_aw_valid(slv_aw_valid), .slv_aw_ready(slv_aw_ready),
    .slv_w_data(slv_w_data), .slv_w_strb(slv_w_strb), .slv_w_last(slv_w_last), .slv_w_user(slv_w_user),
    .slv_w_valid(slv_w_valid), .slv_w_ready(slv_w_ready),
    .slv_b_id(slv_b_id), .slv_b_resp(slv_b_resp), .slv_b_user(slv_b_user), .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready),
    .slv_ar_id(slv_ar_id), .slv_ar_addr(slv_ar_addr), .slv_ar_len(slv_ar_len), .slv_ar_size(slv_ar_size),
    .slv_ar_burst(slv_ar_burst), .slv_ar_lock(slv_ar_lock), .slv_ar_cache(slv_ar_cache), .slv_ar_prot(slv_ar_prot),
    .slv_ar_qos(slv_ar_qos), .slv_ar_region(slv_ar_region), .slv_ar_user(slv_ar_user),
    .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready),
    .slv_r_id(slv_r_id), .slv_r_data(slv_r_data), .slv_r_resp(slv_r_resp), .slv_r_last(slv_r_last),
    .slv_r_user(slv_r_user), .slv_r_valid(slv_r_valid), .slv_r_ready(slv_r_ready),
    .mst_aw_id(mst_aw_id), .mst_aw_addr(mst_aw_addr), .mst_aw_len(mst_aw_len), .mst_aw_size(mst_aw_size),
    .mst_aw_burst(mst_aw_burst), .mst_aw_lock(mst_aw_lock), .mst_aw_cache(mst_aw_cache), .mst_aw_prot(mst_aw_prot),
    .mst_aw_qos(mst_aw_qos), .mst_aw_region(mst_aw_region), .mst_aw_user(mst_aw_user),
    .mst_aw_valid(mst_aw_valid), .mst_aw_ready(mst_aw_ready),
    .mst_w_data(mst_w_data), .mst_w_strb(mst_w_strb), .mst_w_last(mst_w_last), .mst_w_user(mst_w_user),
    .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready),
    .mst_b_id(mst_b_id), .mst_b_resp(mst_b_resp), .mst_b_user(mst_b_user), .mst_b_valid(mst_b_valid), .mst_b_ready(mst_b_ready),
    .mst_ar_id(mst_ar_id), .mst_ar_addr(mst_ar_addr), .mst_ar_len(mst_ar_len), .mst_ar_size(mst_ar_size),
    .mst_ar_burst(mst_ar_burst), .mst_ar_lock(mst_ar_lock), .mst_ar_cache(mst_ar_cache), .mst_ar_prot(mst_ar_prot),
    .mst_ar_qos(mst_ar_qos), .mst_ar_region(mst_ar_region), .mst_ar_user(mst_ar_user),
    .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready),
    .mst_r_id(mst_r_id), .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp), .mst_r_last(mst_r_last),
    .mst_r_user(mst_r_user), .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready),
    .err_cnt(err_cnt), .err_addr(err_addr), .err_pulse(err_pulse)
  );

  axi_addr_guard #(.CNT_W(2)) u_sat (
    .aclk(aclk), .areset(areset),
    .slv_aw_id(slv_aw_id), .slv_aw_addr(slv_aw_addr), .slv_aw_len(slv_aw_len), .slv_aw_size(slv_aw_size),
    .slv_aw_burst(slv_aw_burst), .slv_aw_lock(slv_aw_lock), .slv_aw_cache(slv_aw_cache), .slv_aw_prot(slv_aw_prot),
    .slv_aw_qos(slv_aw_qos), .slv_aw_region(slv_aw_region), .slv_aw_user(slv_aw_user),
    .slv_aw_valid(slv_aw_valid), .slv_aw_ready(s_slv_aw_ready),
    .slv_w_data(slv_w_data), .slv_w_strb(slv_w_strb), .slv_w_last(slv_w_last), .slv_w_user(slv_w_user),
    .slv_w_valid(slv_w_valid), .slv_w_ready(s_slv_w_ready),
    .slv_b_id(s_slv_b_id), .slv_b_resp(s_slv_b_resp), .slv_b_user(s_slv_b_user), .slv_b_valid(s_slv_b_valid), .slv_b_ready(slv_b_ready),
    .slv_ar_id(slv_ar_id), .slv_ar_addr(slv_ar_addr), .slv_ar_len(slv_ar_len), .slv_ar_size(slv_ar_size),
    .slv_ar_burst(slv_ar_burst), .slv_ar_lock(slv_ar_lock), .slv_ar_cache(slv_ar_cache), .slv_ar_prot(slv_ar_prot),
    .slv_ar_qos(slv_ar_qos), .slv_ar_region(slv_ar_region), .slv_ar_user(slv_ar_user),
    .slv_ar_valid(slv_ar_valid), .slv_ar_ready(s_slv_ar_ready),
    .slv_r_id(s_slv_r_id), .slv_r_data(s_slv_r_data), .slv_r_resp(s_slv_r_resp), .slv_r_last(s_slv_r_last),
    .slv_r_user(s_slv_r_user), .slv_r_valid(s_slv_r_valid), .slv_r_ready(slv_r_ready),
    .mst_aw_id(s_mst_aw_id), .mst_aw_addr(s_mst_aw_addr), .mst_aw_len(s_mst_aw_len), .mst_aw_size(s_mst_aw_size),
    .mst_aw_burst(s_mst_aw_burst), .mst_aw_lock(s_mst_aw_lock), .mst_aw_cache(s_mst_aw_cache), .mst_aw_prot(s_mst_aw_prot),
    .mst_aw_qos(s_mst_aw_qos), .mst_aw_region(s_mst_aw_region), .mst_aw_user(s_mst_aw_user),
    .mst_aw_valid(s_mst_aw_valid), .mst_aw_ready(mst_aw_ready),
    .mst_w_data(s_mst_w_data), .mst_w_strb(s_mst_w_strb), .mst_w_last(s_mst_w_last), .mst_w_user(s_mst_w_user),
    .mst_w_valid(s_mst_w_valid), .mst_w_ready(mst_w_ready),
    .mst_b_id(mst_b_id), .mst_b_resp(mst_b_resp), .mst_b_user(mst_b_user), .mst_b_valid(mst_b_valid), .mst_b_ready(s_mst_b_ready),
    .mst_ar_id(s_mst_ar_id), .mst_ar_addr(s_mst_ar_addr), .mst_ar_len(s_mst_ar_len), .mst_ar_size(s_mst_ar_size),
    .mst_ar_burst(s_mst_ar_burst), .mst_ar_lock(s_mst_ar_lock), .mst_ar_cache(s_mst_ar_cache), .mst_ar_prot(s_mst_ar_prot),
    .mst_ar_qos(s_mst_ar_qos), .mst_ar_region(s_mst_ar_region), .mst_ar_user(s_mst_ar_user),
    .mst_ar_valid(s_mst_ar_valid), .mst_ar_ready(mst_ar_ready),
    .mst_r_id(mst_r_id), .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp), .mst_r_last(mst_r_last),
    .mst_r_user(mst_r_user), .mst_r_valid(mst_r_valid), .mst_r_ready(s_mst_r_ready),
    .err_cnt(s_err_cnt), .err_addr(s_err_addr), .err_pulse(s_err_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int mst_valid_cnt = 0;
  int pulse_cnt = 0;
  int mirror_diff = 0;
  logic [37:0] mw_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream W beats as seen by the device.
  always @(posedge aclk)
    if (!areset && mst_w_valid && mst_w_ready)
      mw_q.push_back({mst_w_user, mst_w_last, mst_w_strb, mst_w_data});

  always @(negedge aclk) begin
    if (mst_aw_valid || mst_w_valid || mst_ar_valid) mst_valid_cnt++;
    if (err_pulse) pulse_cnt++;
    if ({slv_aw_ready, slv_w_ready, slv_ar_ready, slv_b_id, slv_b_resp, slv_b_user, slv_b_valid,
         slv_r_id, slv_r_data, slv_r_resp, slv_r_last, slv_r_user, slv_r_valid,
         mst_aw_id, mst_aw_addr, mst_aw_len, mst_aw_size, mst_aw_burst, mst_aw_lock, mst_aw_cache,
         mst_aw_prot, mst_aw_qos, mst_aw_region, mst_aw_user, mst_aw_valid,
         mst_w_data, mst_w_strb, mst_w_last, mst_w_user, mst_w_valid, mst_b_ready, mst_r_ready,
         mst_ar_id, mst_ar_addr, mst_ar_len, mst_ar_size, mst_ar_burst, mst_ar_lock, mst_ar_cache,
         mst_ar_prot, mst_ar_qos, mst_ar_region, mst_ar_user, mst_ar_valid, err_addr, err_pulse} !==
        {s_slv_aw_ready, s_slv_w_ready, s_slv_ar_ready, s_slv_b_id, s_slv_b_resp, s_slv_b_user, s_slv_b_valid,
         s_slv_r_id, s_slv_r_data, s_slv_r_resp, s_slv_r_last, s_slv_r_user, s_slv_r_valid,
         s_mst_aw_id, s_mst_aw_addr, s_mst_aw_len, s_mst_aw_size, s_mst_aw_burst, s_mst_aw_lock, s_mst_aw_cache,
         s_mst_aw_prot, s_mst_aw_qos, s_mst_aw_region, s_mst_aw_user, s_mst_aw_valid,
         s_mst_w_data, s_mst_w_strb, s_mst_w_last, s_mst_w_user, s_mst_w_valid, s_mst_b_ready, s_mst_r_ready,
         s_mst_ar_id, s_mst_ar_addr, s_mst_ar_len, s_mst_ar_size, s_mst_ar_burst, s_mst_ar_lock, s_mst_ar_cache,
         s_mst_ar_prot, s_mst_ar_qos, s_mst_ar_region, s_mst_ar_user, s_mst_ar_valid, s_err_addr, s_err_pulse})
      mirror_diff++;
  end

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic set_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    slv_aw_id = id; slv_aw_addr = addr; slv_aw_len = len; slv_aw_size = 3'd2; slv_aw_burst = 2'b01;
    slv_aw_lock = 1'b0; slv_aw_cache = 4'h3; slv_aw_prot = 3'b010; slv_aw_qos = 4'h1;
    slv_aw_region = 4'h2; slv_aw_user = 1'b1;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    slv_ar_id = id; slv_ar_addr = addr; slv_ar_len = len; slv_ar_size = 3'd2; slv_ar_burst = 2'b01;
    slv_ar_lock = 1'b1; slv_ar_cache = 4'h7; slv_ar_prot = 3'b001; slv_ar_qos = 4'h4;
    slv_ar_region = 4'h5; slv_ar_user = 1'b1;
  endtask

  // Wait (bounded) for AW ready with valid already up; completes the handshake.
  task automatic aw_hs(input string tag);
    bit ok = 1'b0;
    slv_aw_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (slv_aw_ready) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
    slv_aw_valid = 1'b0;
    check({tag, "_aw_hs"}, 64'(ok), 64'd1);
  endtask

  task automatic ar_hs(input string tag);
    bit ok = 1'b0;
    slv_ar_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (slv_ar_ready) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
    slv_ar_valid = 1'b0;
    check({tag, "_ar_hs"}, 64'(ok), 64'd1);
  endtask

  // Send n W beats, data = base + i; wlast on the final beat only if with_last.
  task automatic w_send(input string tag, input int n, input logic [31:0] base, input bit with_last);
    for (int i = 0; i < n; i++) begin
      bit ok = 1'b0;
      slv_w_valid = 1'b1; slv_w_data = base + 32'(i); slv_w_strb = 4'hf;
      slv_w_last = with_last && (i == n - 1); slv_w_user = 1'(i);
      for (int k = 0; k < 20; k++) begin
        @(negedge aclk);
        if (slv_w_ready) begin ok = 1'b1; break; end
      end
      @(posedge aclk); #1;
      check({tag, "_w_hs"}, 64'(ok), 64'd1);
    end
    slv_w_valid = 1'b0; slv_w_last = 1'b0;
  endtask

  // In-range write with a downstream device that accepts everything.
  task automatic inrange_write(input string tag, input logic [3:0] id, input logic [31:0] addr, input int beats);
    mst_aw_ready = 1'b1; mst_w_ready = 1'b1;
    mw_q.delete();
    // W ahead of AW must stall
    slv_w_valid = 1'b1; slv_w_data = 32'h5555_aaaa;
    #1;
    check({tag, "_w_before_aw"}, 64'({slv_w_ready, mst_w_valid}), 64'd0);
    slv_w_valid = 1'b0;
    set_aw(id, addr, 8'(beats - 1));
    slv_aw_valid = 1'b1;
    #1;
    check({tag, "_mst_aw"}, 64'({mst_aw_valid, mst_aw_id, mst_aw_len, mst_aw_size, mst_aw_burst, mst_aw_lock,
                                 mst_aw_cache, mst_aw_prot, mst_aw_qos, mst_aw_region, mst_aw_user}),
          64'({1'b1, id, 8'(beats - 1), 3'd2, 2'b01, 1'b0, 4'h3, 3'b010, 4'h1, 4'h2, 1'b1}));
    check({tag, "_mst_aw_addr"}, 64'(mst_aw_addr), 64'(addr));
    aw_hs(tag);
    w_send(tag, beats, 32'h0000_00a0, 1'b1);
    check({tag, "_mst_beats"}, 64'(mw_q.size()), 64'(beats));
    for (int i = 0; i < beats && i < mw_q.size(); i++)
      check({tag, "_mst_w"}, 64'(mw_q[i]),
            64'({1'(i), (i == beats - 1), 4'hf, 32'h0000_00a0 + 32'(i)}));
    mst_b_valid = 1'b1; mst_b_id = id; mst_b_resp = 2'b00; mst_b_user = 1'b1; slv_b_ready = 1'b1;
    @(negedge aclk);
    check({tag, "_b"}, 64'({slv_b_valid, slv_b_id, slv_b_resp, slv_b_user, mst_b_ready}),
          64'({1'b1, id, 2'b00, 1'b1, 1'b1}));
    tick();
    mst_b_valid = 1'b0; slv_b_ready = 1'b0;
    check({tag, "_b_done"}, 64'(slv_b_valid), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, mv0, beats;
    bit [4:0] pat;
    logic [31:0] c0;
    areset = 1'b1;
    set_aw(4'd0, 32'h0, 8'd0); set_ar(4'd0, 32'h0, 8'd0);
    slv_aw_valid = 0; slv_ar_valid = 0; slv_w_valid = 0; slv_w_data = 0; slv_w_strb = 0;
    slv_w_last = 0; slv_w_user = 0; slv_b_ready = 0; slv_r_ready = 0;
    mst_aw_ready = 0; mst_w_ready = 0; mst_ar_ready = 0; mst_b_valid = 0; mst_b_id = 0;
    mst_b_resp = 0; mst_b_user = 0; mst_r_valid = 0; mst_r_id = 0; mst_r_data = 0;
    mst_r_resp = 0; mst_r_last = 0; mst_r_user = 0;
    repeat (3) @(posedge aclk);
    #1;
    // reset state
    check("rst_status", 64'({err_cnt, err_addr, err_pulse}), 64'd0);
    check("rst_valids", 64'({slv_b_valid, slv_r_valid, mst_aw_valid, mst_w_valid, mst_ar_valid,
                             slv_aw_ready, slv_ar_ready, slv_w_ready}), 64'd0);
    areset = 1'b0;
    tick();

    // in-range write passes through
    inrange_write("wr_in", 4'd5, 32'h1c00_0040, 4);
    check("wr_in_cnt", 64'(err_cnt), 64'd0);

    // out-of-range write is absorbed and answered with DECERR
    p0 = pulse_cnt; mv0 = mst_valid_cnt;
    set_aw(4'd9, 32'h2000_0000, 8'd7);
    slv_aw_valid = 1'b1;
    #1;
    check("wr_err_mst_aw", 64'(mst_aw_valid), 64'd0);
    aw_hs("wr_err");
    check("wr_err_pulse", 64'(err_pulse), 64'd1);
    w_send("wr_err", 8, 32'h0000_0100, 1'b1);
    check("wr_err_b_first", 64'({slv_b_valid, slv_b_id, slv_b_resp, slv_b_user}), 64'({1'b1, 4'd9, 2'b11, 1'b0}));
    tick();
    check("wr_err_b_hold", 64'({slv_b_valid, slv_b_id, slv_b_resp, slv_b_user}), 64'({1'b1, 4'd9, 2'b11, 1'b0}));
    slv_b_ready = 1'b1;
    tick();
    slv_b_ready = 1'b0;
    check("wr_err_b_done", 64'(slv_b_valid), 64'd0);
    check("wr_err_cnt", 64'(err_cnt), 64'd1);
    check("wr_err_addr", 64'(err_addr), 64'h2000_0000);
    check("wr_err_mst_idle", 64'(mst_valid_cnt - mv0), 64'd0);
    check("wr_err_pulses", 64'(pulse_cnt - p0), 64'd1);

    // out-of-range read, r_ready pattern 1,0,1,1,1
    set_ar(4'd3, 32'h0000_1000, 8'd3);
    ar_hs("rd_err");
    pat = 5'b11101; beats = 0;
    for (int i = 0; i < 5; i++) begin
      slv_r_ready = pat[i];
      @(negedge aclk);
      check("rd_err_beat", 64'({slv_r_valid, slv_r_id, slv_r_resp, slv_r_last, slv_r_user, slv_r_data}),
            64'({1'b1, 4'd3, 2'b11, (beats == 3), 1'b0, 32'h0}));
      if (pat[i]) beats++;
      @(posedge aclk); #1;
    end
    slv_r_ready = 1'b0;
    check("rd_err_done", 64'(slv_r_valid), 64'd0);
    check("rd_err_cnt", 64'(err_cnt), 64'd2);
    check("rd_err_addr", 64'(err_addr), 64'h0000_1000);

    // in-range read passes through
    mst_ar_ready = 1'b1;
    set_ar(4'd6, 32'h1cff_fff0, 8'd0);
    slv_ar_valid = 1'b1;
    #1;
    check("rd_in_mst_ar", 64'({mst_ar_valid, mst_ar_id, mst_ar_len, mst_ar_size, mst_ar_burst, mst_ar_lock,
                               mst_ar_cache, mst_ar_prot, mst_ar_qos, mst_ar_region, mst_ar_user}),
          64'({1'b1, 4'd6, 8'd0, 3'd2, 2'b01, 1'b1, 4'h7, 3'b001, 4'h4, 4'h5, 1'b1}));
    check("rd_in_mst_ar_addr", 64'(mst_ar_addr), 64'h1cff_fff0);
    ar_hs("rd_in");
    mst_r_valid = 1'b1; mst_r_id = 4'd6; mst_r_data = 32'hdead_beef; mst_r_resp = 2'b00;
    mst_r_last = 1'b1; mst_r_user = 1'b1; slv_r_ready = 1'b1;
    @(negedge aclk);
    check("rd_in_r", 64'({slv_r_valid, slv_r_id, slv_r_resp, slv_r_last, slv_r_user, mst_r_ready}),
          64'({1'b1, 4'd6, 2'b00, 1'b1, 1'b1, 1'b1}));
    check("rd_in_r_data", 64'(slv_r_data), 64'hdead_beef);
    tick();
    mst_r_valid = 1'b0; mst_r_last = 1'b0; slv_r_ready = 1'b0;
    check("rd_in_cnt", 64'(err_cnt), 64'd2);

    // simultaneous AW and AR errors
    p0 = pulse_cnt;
    set_aw(4'd1, 32'h3000_0000, 8'd0);
    set_ar(4'd2, 32'h4000_0000, 8'd0);
    slv_aw_valid = 1'b1; slv_ar_valid = 1'b1;
    @(negedge aclk);
    check("dual_ready", 64'({slv_aw_ready, slv_ar_ready}), 64'd3);
    tick();
    slv_aw_valid = 1'b0; slv_ar_valid = 1'b0;
    check("dual_pulse", 64'(err_pulse), 64'd1);
    check("dual_cnt", 64'(err_cnt), 64'd4);
    check("dual_addr", 64'(err_addr), 64'h4000_0000);
    w_send("dual", 1, 32'h0000_0200, 1'b1);
    slv_b_ready = 1'b1; slv_r_ready = 1'b1;
    @(negedge aclk);
    check("dual_b", 64'({slv_b_valid, slv_b_id, slv_b_resp}), 64'({1'b1, 4'd1, 2'b11}));
    check("dual_r", 64'({slv_r_valid, slv_r_id, slv_r_resp, slv_r_last}), 64'({1'b1, 4'd2, 2'b11, 1'b1}));
    tick();
    slv_b_ready = 1'b0; slv_r_ready = 1'b0;
    check("dual_done", 64'({slv_b_valid, slv_r_valid}), 64'd0);
    check("dual_pulses", 64'(pulse_cnt - p0), 64'd1);

    // reset in the middle of an absorbed write burst
    set_aw(4'd4, 32'h5000_0000, 8'd3);
    aw_hs("rst_mid");
    w_send("rst_mid", 2, 32'h0000_0300, 1'b0);
    slv_w_valid = 1'b1; slv_w_data = 32'h0000_0302;
    areset = 1'b1;
    @(negedge aclk);
    check("rst_mid_valids", 64'({slv_b_valid, slv_r_valid, mst_aw_valid, mst_w_valid, mst_ar_valid,
                                 slv_aw_ready, slv_ar_ready, slv_w_ready}), 64'd0);
    check("rst_mid_status", 64'({err_cnt, err_addr}), 64'd0);
    slv_w_valid = 1'b0;
    tick();
    areset = 1'b0;
    tick();
    inrange_write("wr_after_rst", 4'd7, 32'h1c12_3400, 2);
    check("wr_after_rst_cnt", 64'(err_cnt), 64'd0);

    // five error reads: 16-bit counter reaches 5, 2-bit counter clamps at 3
    for (int i = 0; i < 5; i++) begin
      set_ar(4'(i), 32'h0000_2000 + 32'(i * 16), 8'd0);
      ar_hs("sat");
      slv_r_ready = 1'b1;
      @(negedge aclk);
      check("sat_r", 64'({slv_r_valid, slv_r_id, slv_r_last}), 64'({1'b1, 4'(i), 1'b1}));
      tick();
      slv_r_ready = 1'b0;
    end
    c0 = 32'(err_cnt);
    check("sat_main_cnt", 64'(c0), 64'd5);
    check("sat_small_cnt", 64'(s_err_cnt), 64'd3);
    check("sat_addr", 64'(err_addr), 64'h0000_2040);
    check("sat_mirror", 64'(mirror_diff), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
